// File: rtl/ex_muldiv_if.sv
// Request/response bundle between the EX-stage issue logic and the iterative
// multiply/divide unit.
interface ex_muldiv_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;

  modport master (
    output start, op, a, b, flush,
    input  busy, stall, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, stall, done, hi, lo, div_by_zero
  );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit: radix-2 shift-add multiply and
// restoring divide over 32 cycles, with sign fix-up and HI/LO result registers.
module ex_muldiv (
  input  logic       clk,
  input  logic       rst_n,
  ex_muldiv_if.slave mif
);
  typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        dbz_q, dbz_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [1:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] opnd_q, opnd_d;
  logic [63:0] acc_q, acc_d;
  logic        neg_q, neg_d;
  logic        rneg_q, rneg_d;

  logic        accept;
  logic        is_div;
  logic        is_signed;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [32:0] mul_sum;
  logic [32:0] div_diff;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  assign accept    = mif.start & ~mif.flush;
  assign is_div    = op_q[1];
  assign is_signed = op_q[0];

  assign mif.stall       = accept | busy_q;
  assign mif.busy        = busy_q;
  assign mif.done        = done_q;
  assign mif.hi          = hi_q;
  assign mif.lo          = lo_q;
  assign mif.div_by_zero = dbz_q;

  assign abs_a = (is_signed && a_q[31]) ? -a_q : a_q;
  assign abs_b = (is_signed && b_q[31]) ? -b_q : b_q;

  // acc = {partial product, multiplier} for MUL, {remainder, dividend/quotient} for DIV
  assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
  // Bit 32 is the borrow: set when the shifted remainder is below the divisor.
  assign div_diff = acc_q[63:31] - {1'b0, opnd_q};

  assign prod_fix = neg_q  ? -acc_q         : acc_q;
  assign quo_fix  = neg_q  ? -acc_q[31:0]   : acc_q[31:0];
  assign rem_fix  = rneg_q ? -acc_q[63:32]  : acc_q[63:32];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          state_d = PREP;
          op_d    = mif.op;
          a_d     = mif.a;
          b_d     = mif.b;
          dbz_d   = 1'b0;
        end
      end
      PREP: begin
        if (mif.flush) begin
          state_d = IDLE;
        end else begin
          cnt_d  = 5'd0;
          neg_d  = is_signed & (a_q[31] ^ b_q[31]);
          rneg_d = is_signed & is_div & a_q[31];
          opnd_d = is_div ? abs_b : abs_a;
          acc_d  = {32'd0, (is_div ? abs_a : abs_b)};
          if (is_div && (b_q == 32'd0)) begin
            state_d = DONE;
            hi_d    = a_q;
            lo_d    = '1;
            dbz_d   = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (mif.flush) begin
          state_d = IDLE;
        end else begin
          if (is_div)
            acc_d = div_diff[32] ? {acc_q[62:0], 1'b0}
                                 : {div_diff[31:0], acc_q[30:0], 1'b1};
          else
            acc_d = {mul_sum, acc_q[31:1]};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = FIX;
        end
      end
      FIX: begin
        if (mif.flush) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
          if (is_div) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[63:32];
            lo_d = prod_fix[31:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == PREP) || (state_d == RUN) || (state_d == FIX);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Operand/accumulator datapath is only meaningful while the FSM is active.
  always_ff @(posedge clk) begin
    op_q   <= op_d;
    a_q    <= a_d;
    b_q    <= b_d;
    opnd_q <= opnd_d;
    acc_q  <= acc_d;
    neg_q  <= neg_d;
    rneg_q <= rneg_d;
  end
endmodule

// File: tb/tb_ex_muldiv.sv
// Directed-vector bench for ex_muldiv: the driver queues expected HI/LO and
// completion cycle; an independent monitor checks every done pulse.
module tb_ex_muldiv;
  logic clk;
  logic rst_n;
  int   cyc;
  int   total;
  int   bad;
  int   last_c0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];

  ex_muldiv_if mif();

  ex_muldiv dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mif   (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && mif.done) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done: hi=%h lo=%h at cycle %0d", mif.hi, mif.lo, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (mif.hi !== e.hi || mif.lo !== e.lo || mif.div_by_zero !== e.dbz || cyc != e.cyc) begin
          bad++;
          $display("FAIL result: got hi=%h lo=%h dbz=%b cyc=%0d expected hi=%h lo=%h dbz=%b cyc=%0d",
                   mif.hi, mif.lo, mif.div_by_zero, cyc, e.hi, e.lo, e.dbz, e.cyc);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge of cycle 1.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input logic [31:0] ehi, input logic [31:0] elo,
                       input logic edbz, input int lat);
    exp_t e;
    mif.start = 1'b1;
    mif.op    = op;
    mif.a     = a;
    mif.b     = b;
    #1 chk("stall_start_cycle", {63'd0, mif.stall}, 64'd1);
    @(posedge clk);
    #1;
    last_c0 = cyc;
    if (push) begin
      e.hi = ehi; e.lo = elo; e.dbz = edbz; e.cyc = cyc + lat - 1;
      exp_q.push_back(e);
    end
    mif.start = 1'b0;
    mif.a     = $urandom;
    mif.b     = $urandom;
    mif.op    = 2'($urandom_range(0, 3));
    @(negedge clk);
  endtask

  task automatic wait_done(input string nm);
    int n;
    bit sok;
    n   = 0;
    sok = 1'b1;
    while (!mif.done && n < 60) begin
      if (!mif.stall || !mif.busy) sok = 1'b0;
      @(negedge clk);
      n++;
    end
    total++;
    if (!mif.done) begin
      bad++;
      $display("FAIL %s_timeout: no done within %0d cycles", nm, n);
    end
    chk({nm, "_stall_while_busy"}, {63'd0, sok}, 64'd1);
    chk({nm, "_done_cycle_stall_busy"}, {62'd0, mif.stall, mif.busy}, 64'd0);
  endtask

  task automatic run_op(input string nm, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input logic edbz, input int lat);
    issue(op, a, b, 1'b1, ehi, elo, edbz, lat);
    wait_done(nm);
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    mif.start = 1'b0;
    mif.flush = 1'b0;
    mif.op    = 2'b00;
    mif.a     = 32'd0;
    mif.b     = 32'd0;

    #12;
    chk("reset_outputs", {mif.busy, mif.done, mif.div_by_zero, mif.stall, mif.hi, mif.lo}, 68'd0);
    mif.start = 1'b1;
    #1 chk("reset_stall_follows_start", {63'd0, mif.stall}, 64'd1);
    mif.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("mult_neg3x7",    2'b01, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 35);
    run_op("multu_ffxff",    2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 35);
    run_op("mult_m1xm1",     2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 35);
    run_op("mult_minxmin",   2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 35);
    run_op("mult_m1xmin",    2'b01, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 32'h80000000, 1'b0, 35);
    run_op("div_m7d2",       2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 35);
    run_op("div_7dm2",       2'b11, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 35);
    run_op("div_min_dm1",    2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 35);
    run_op("divu_ff_d16",    2'b10, 32'hFFFFFFFF, 32'd16,       32'h0000000F, 32'h0FFFFFFF, 1'b0, 35);
    run_op("divu_100_d0",    2'b10, 32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF, 1'b1, 2);

    repeat (4) @(negedge clk);
    chk("dbz_held_idle", {63'd0, mif.div_by_zero}, 64'd1);
    issue(2'b10, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, 1'b0, 35);
    chk("dbz_cleared_on_start", {63'd0, mif.div_by_zero}, 64'd0);
    wait_done("divu_100_d7");
    @(negedge clk);

    // Flush in cycle 10 of a MULTU: no done, HI/LO keep 2/14.
    issue(2'b00, 32'd5, 32'd6, 1'b0, 32'd0, 32'd0, 1'b0, 35);
    while (cyc < last_c0 + 9) @(negedge clk);
    mif.flush = 1'b1;
    @(negedge clk);
    chk("flush_busy_stall_done", {61'd0, mif.busy, mif.stall, mif.done}, 64'd0);
    mif.flush = 1'b0;
    repeat (40) @(negedge clk);
    chk("flush_hilo_kept", {mif.hi, mif.lo}, {32'd2, 32'd14});

    // start and flush together: dropped.
    mif.start = 1'b1;
    mif.flush = 1'b1;
    mif.op    = 2'b00;
    mif.a     = 32'd9;
    mif.b     = 32'd9;
    #1 chk("start_flush_stall", {63'd0, mif.stall}, 64'd0);
    @(negedge clk);
    chk("start_flush_busy", {63'd0, mif.busy}, 64'd0);
    mif.start = 1'b0;
    mif.flush = 1'b0;
    repeat (40) @(negedge clk);

    // Back-to-back: second start in the DONE cycle; stray start while busy.
    issue(2'b00, 32'd3, 32'd4, 1'b1, 32'd0, 32'd12, 1'b0, 35);
    wait_done("b2b_first");
    issue(2'b11, 32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 35);
    repeat (5) @(negedge clk);
    mif.start = 1'b1;
    mif.op    = 2'b10;
    mif.a     = 32'd1;
    mif.b     = 32'd0;
    @(negedge clk);
    mif.start = 1'b0;
    wait_done("b2b_second");
    @(negedge clk);

    // Asynchronous reset in cycle 20 of a MULTU.
    issue(2'b00, 32'd11, 32'd13, 1'b0, 32'd0, 32'd0, 1'b0, 35);
    while (cyc < last_c0 + 19) @(negedge clk);
    rst_n = 1'b0;
    #1 chk("async_reset_outputs",
           {mif.busy, mif.done, mif.div_by_zero, mif.stall, mif.hi, mif.lo}, 68'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_reset_idle", {63'd0, mif.busy}, 64'd0);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
